// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared defaults, FSM state type and a reference reduction
// (schoolbook long division by f) for GF(2^m) reduction.
`default_nettype none

package gf2m_pkg;

    localparam int                 DEF_N    = 256;
    localparam logic [DEF_N-1:0]   DEF_POLY = 256'h425;
    localparam int                 MAX_N    = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cancels every coefficient at or above x^n by XORing in a shifted copy of f.
    // Inputs must have no coefficient at or above x^(2n).
    function automatic logic [MAX_N-1:0] ref_reduce(
        input logic [2*MAX_N-1:0] c,
        input int                 n,
        input logic [MAX_N-1:0]   poly
    );
        logic [2*MAX_N-1:0] r;
        r = c;
        for (int i = 2*MAX_N-1; i >= 0; i--) begin
            if (i >= n && i < 2*n && r[i]) begin
                r[i] = 1'b0;
                r    = r ^ ({{MAX_N{1'b0}}, poly} << (i - n));
            end
        end
        return r[MAX_N-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf2m_reduce_if.sv
// gf2m_reduce_if: valid/ready input and output channels of the reduction stage.
`default_nettype none

interface gf2m_reduce_if
    import gf2m_pkg::*;
#(
    parameter int N = DEF_N
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic           busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/gf2_mulx.sv
// gf2_mulx: combinational a(x) * x mod f(x), f = x^N + POLY.
`default_nettype none

module gf2_mulx #(
    parameter int           N    = 8,
    parameter logic [N-1:0] POLY = 8'h1B
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    assign y = {a[N-2:0], 1'b0} ^ (a[N-1] ? POLY : {N{1'b0}});
endmodule

`default_nettype wire

// File: rtl/gf2m_reduce.sv
// gf2m_reduce: bit-serial Horner reduction of a 2N-bit carry-less product
// modulo f(x) = x^N + POLY, one low-half coefficient per cycle.
`default_nettype none

module gf2m_reduce
    import gf2m_pkg::*;
#(
    parameter int           N    = DEF_N,
    parameter logic [N-1:0] POLY = DEF_POLY[N-1:0]
) (
    input  logic         clk,
    input  logic         rst,
    gf2m_reduce_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc_x;

    gf2_mulx #(
        .N    (N),
        .POLY (POLY)
    ) u_mulx (
        .a (acc),
        .y (acc_x)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (cnt == '0)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // The upper half already has degree < N, so it seeds acc directly.
                    if (bus.in_valid) begin
                        acc   <= bus.in_data[2*N-1:N];
                        shreg <= bus.in_data[N-1:0];
                        cnt   <= CW'(N - 1);
                    end
                end
                RUN: begin
                    acc   <= acc_x ^ {{(N-1){1'b0}}, shreg[N-1]};
                    shreg <= shreg << 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = acc;
endmodule

`default_nettype wire
